// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register hazard scoreboard.
package reg_scoreboard_pkg;

  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register.
// Saturates at both ends: an increment at max and a decrement at zero are dropped.
// A simultaneous increment and effective decrement cancel out.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_one,
  output logic o_max,
  output logic o_next_zero
);

  localparam logic [CNT_W-1:0] LP_MAX = '1;
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_dec_ok;

  // Next count: a decrement only counts when there is something to retire.
  always_comb begin
    w_count_nxt = r_count;
    w_dec_ok    = i_dec & (r_count != '0);
    if (i_inc & ~w_dec_ok & (r_count != LP_MAX)) begin
      w_count_nxt = r_count + LP_ONE;
    end else if (w_dec_ok & ~i_inc) begin
      w_count_nxt = r_count - LP_ONE;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_zero      = (r_count == '0);
  assign o_one       = (r_count == LP_ONE);
  assign o_max       = (r_count == LP_MAX);
  assign o_next_zero = (w_count_nxt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writes per register,
// stalls on RAW or counter saturation, and sequences a drain on flush.
//
// state | meaning
// RUN   | normal issue; stall only on hazards or an incoming flush request
// DRAIN | issue blocked until every pending write has been written back
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_reg_write,
  input  logic [REG_ADDR_W-1:0] i_id_write_reg,
  output logic                  o_id_stall,
  output logic                  o_id_issue,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_write_reg,
  input  logic                  i_flush_req,
  output logic                  o_flush_done,
  output logic                  o_busy
);

  sb_state_t r_state;
  sb_state_t w_state_nxt;
  logic      r_flush_done;
  logic      w_flush_done_nxt;

  // Register 0 is never tracked: it always reads as an empty, non-full counter.
  logic [NREG-1:0] w_zero;
  logic [NREG-1:0] w_one;
  logic [NREG-1:0] w_max;
  logic [NREG-1:0] w_next_zero;
  logic [NREG-1:1] w_inc;
  logic [NREG-1:1] w_dec;

  logic w_stall;
  logic w_issue;
  logic w_rs_bypass;
  logic w_rt_bypass;
  logic w_rs_haz;
  logic w_rt_haz;
  logic w_raw;
  logic w_sat;
  logic w_all_zero_nxt;

  assign w_zero[0]      = 1'b1;
  assign w_one[0]       = 1'b0;
  assign w_max[0]       = 1'b0;
  assign w_next_zero[0] = 1'b1;

  generate
    for (genvar g = 1; g < NREG; g++) begin : g_cnt
      assign w_inc[g] = w_issue & i_id_reg_write & (i_id_write_reg == REG_ADDR_W'(g));
      assign w_dec[g] = i_wb_reg_write & (i_wb_write_reg == REG_ADDR_W'(g));

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_inc       (w_inc[g]),
        .i_dec       (w_dec[g]),
        .o_zero      (w_zero[g]),
        .o_one       (w_one[g]),
        .o_max       (w_max[g]),
        .o_next_zero (w_next_zero[g])
      );
    end
  endgenerate

  // A source whose last pending write retires this very cycle may be forwarded.
  assign w_rs_bypass = BYPASS & i_wb_reg_write & (i_wb_write_reg == i_id_rs) & w_one[i_id_rs];
  assign w_rt_bypass = BYPASS & i_wb_reg_write & (i_wb_write_reg == i_id_rt) & w_one[i_id_rt];
  assign w_rs_haz    = i_id_uses_rs & ~w_zero[i_id_rs] & ~w_rs_bypass;
  assign w_rt_haz    = i_id_uses_rt & ~w_zero[i_id_rt] & ~w_rt_bypass;
  assign w_raw       = w_rs_haz | w_rt_haz;
  assign w_sat       = i_id_reg_write & w_max[i_id_write_reg];

  // Stall is kept outside the FSM process: the counters' next-zero flags
  // depend on issue, and the FSM reads those flags.
  assign w_stall = (r_state == ST_DRAIN) |
                   (i_id_valid & (w_raw | w_sat)) |
                   i_flush_req;
  assign w_issue = i_id_valid & ~w_stall;

  assign w_all_zero_nxt = &w_next_zero;

  // Next state and flush-complete pulse.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_all_zero_nxt) begin
          w_state_nxt      = ST_RUN;
          w_flush_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and pulse registers; reset aborts a drain without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

  assign o_id_stall   = w_stall;
  assign o_id_issue   = w_issue;
  assign o_flush_done = r_flush_done;
  assign o_busy       = ~(&w_zero);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; a second instance with BYPASS=0 shares
// the same stimulus so both forwarding behaviours can be compared.
module tb_reg_scoreboard;

  logic       clk;
  logic       i_reset;
  logic       i_id_valid;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_uses_rs;
  logic       i_id_uses_rt;
  logic       i_id_reg_write;
  logic [4:0] i_id_write_reg;
  logic       i_wb_reg_write;
  logic [4:0] i_wb_write_reg;
  logic       i_flush_req;

  logic stall1, issue1, fdone1, busy1;
  logic stall0, issue0, fdone0, busy0;

  int n_pass  = 0;
  int n_total = 0;

  reg_scoreboard #(.CNT_W(2), .BYPASS(1'b1)) u_dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_id_valid     (i_id_valid),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_uses_rs   (i_id_uses_rs),
    .i_id_uses_rt   (i_id_uses_rt),
    .i_id_reg_write (i_id_reg_write),
    .i_id_write_reg (i_id_write_reg),
    .o_id_stall     (stall1),
    .o_id_issue     (issue1),
    .i_wb_reg_write (i_wb_reg_write),
    .i_wb_write_reg (i_wb_write_reg),
    .i_flush_req    (i_flush_req),
    .o_flush_done   (fdone1),
    .o_busy         (busy1)
  );

  reg_scoreboard #(.CNT_W(2), .BYPASS(1'b0)) u_dut_nobyp (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_id_valid     (i_id_valid),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_id_uses_rs   (i_id_uses_rs),
    .i_id_uses_rt   (i_id_uses_rt),
    .i_id_reg_write (i_id_reg_write),
    .i_id_write_reg (i_id_write_reg),
    .o_id_stall     (stall0),
    .o_id_issue     (issue0),
    .i_wb_reg_write (i_wb_reg_write),
    .i_wb_write_reg (i_wb_write_reg),
    .i_flush_req    (i_flush_req),
    .o_flush_done   (fdone0),
    .o_busy         (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic [4:0] wr);
    i_id_valid     = v;
    i_id_rs        = rs;
    i_id_rt        = rt;
    i_id_uses_rs   = urs;
    i_id_uses_rt   = urt;
    i_id_reg_write = rw;
    i_id_write_reg = wr;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r);
    i_wb_reg_write = en;
    i_wb_write_reg = r;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_wb(1'b0, 5'd0);
    i_flush_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall1); else n_pass++;
    n_total++; if (issue1 !== 1'b1) $display("FAIL rst_issue: got %b want 1", issue1); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy1); else n_pass++;
    n_total++; if (fdone1 !== 1'b0) $display("FAIL rst_fdone: got %b want 0", fdone1); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL raw_wr_issue: got %b want 1", issue1); else n_pass++;
    n_total++; if (issue0 !== 1'b1) $display("FAIL raw_wr_issue_nobyp: got %b want 1", issue0); else n_pass++;
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL raw_stall: got %b want 1", stall1); else n_pass++;
    n_total++; if (stall0 !== 1'b1) $display("FAIL raw_stall_nobyp: got %b want 1", stall0); else n_pass++;
    n_total++; if (busy1 !== 1'b1) $display("FAIL raw_busy: got %b want 1", busy1); else n_pass++;
    tick();
    set_wb(1'b1, 5'd5);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL raw_bypass_issue: got %b want 1", issue1); else n_pass++;
    n_total++; if (stall0 !== 1'b1) $display("FAIL raw_nobyp_wbcycle_stall: got %b want 1", stall0); else n_pass++;
    tick();
    set_wb(1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (issue0 !== 1'b1) $display("FAIL raw_nobyp_late_issue: got %b want 1", issue0); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL raw_busy_clear: got %b want 0", busy1); else n_pass++;
    tick();
    // rt source path, gated by uses_rt
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    set_id(1'b1, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b0) $display("FAIL rt_unused_stall: got %b want 0", stall1); else n_pass++;
    i_id_uses_rt = 1'b1;
    #1;
    n_total++; if (stall1 !== 1'b1) $display("FAIL rt_stall: got %b want 1", stall1); else n_pass++;
    tick();
    set_wb(1'b1, 5'd6);
    tick();
    idle();
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL rt_busy_clear: got %b want 0", busy1); else n_pass++;
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL r0_wr_issue: got %b want 1", issue1); else n_pass++;
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL r0_busy: got %b want 0", busy1); else n_pass++;
    n_total++; if (stall1 !== 1'b0) $display("FAIL r0_read_stall: got %b want 0", stall1); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
      @(negedge clk);
      n_total++; if (issue1 !== 1'b1) $display("FAIL sat_fill_issue%0d: got %b want 1", k, issue1); else n_pass++;
      tick();
    end
    set_wb(1'b1, 5'd7);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL sat_full_stall: got %b want 1", stall1); else n_pass++;
    tick();
    set_wb(1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL sat_fourth_issue: got %b want 1", issue1); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL sat_refull_stall: got %b want 1", stall1); else n_pass++;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      set_wb(1'b1, 5'd7);
      @(negedge clk);
      n_total++; if (busy1 !== 1'b1) $display("FAIL sat_drain_busy%0d: got %b want 1", k, busy1); else n_pass++;
    end
    tick();
    set_wb(1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL sat_empty_busy: got %b want 0", busy1); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    set_wb(1'b1, 5'd3);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL same_issue: got %b want 1", issue1); else n_pass++;
    tick();
    set_wb(1'b0, 5'd0);
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL same_pend_kept_stall: got %b want 1", stall1); else n_pass++;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    set_wb(1'b1, 5'd3);
    tick();
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL same_spurious_wb_busy: got %b want 0", busy1); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    i_flush_req = 1'b1;
    @(negedge clk);
    n_total++; if (issue1 !== 1'b0) $display("FAIL flush_req_blocks_issue: got %b want 0", issue1); else n_pass++;
    tick();
    i_flush_req = 1'b0;
    set_wb(1'b1, 5'd4);
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL drain_stall0: got %b want 1", stall1); else n_pass++;
    tick();
    i_flush_req = 1'b1;
    set_wb(1'b1, 5'd9);
    @(negedge clk);
    n_total++; if (fdone1 !== 1'b0) $display("FAIL drain_fdone_early: got %b want 0", fdone1); else n_pass++;
    tick();
    i_flush_req = 1'b0;
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL drain_stall_last: got %b want 1", stall1); else n_pass++;
    n_total++; if (busy1 !== 1'b1) $display("FAIL drain_busy_last: got %b want 1", busy1); else n_pass++;
    tick();
    set_wb(1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (fdone1 !== 1'b1) $display("FAIL flush_done_pulse: got %b want 1", fdone1); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL flush_busy_zero: got %b want 0", busy1); else n_pass++;
    n_total++; if (issue1 !== 1'b1) $display("FAIL flush_issue_resume: got %b want 1", issue1); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (fdone1 !== 1'b0) $display("FAIL flush_done_single: got %b want 0", fdone1); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    i_flush_req = 1'b1;
    tick();
    i_flush_req = 1'b0;
    @(negedge clk);
    n_total++; if (stall1 !== 1'b1) $display("FAIL rd_drain_stall: got %b want 1", stall1); else n_pass++;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (issue1 !== 1'b1) $display("FAIL rd_run_issue: got %b want 1", issue1); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL rd_busy: got %b want 0", busy1); else n_pass++;
    n_total++; if (fdone1 !== 1'b0) $display("FAIL rd_fdone0: got %b want 0", fdone1); else n_pass++;
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    set_wb(1'b1, 5'd2);
    @(negedge clk);
    n_total++; if (fdone1 !== 1'b0) $display("FAIL rd_fdone1: got %b want 0", fdone1); else n_pass++;
    tick();
    set_wb(1'b0, 5'd0);
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL rd_spurious_wb_busy: got %b want 0", busy1); else n_pass++;
    tick();
    idle();
  endtask

  initial begin
    i_reset = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_zero_reg();
    test_saturation();
    test_same_cycle();
    test_flush();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
